cache_ctrl: RTL

CACHE_CTRL -- requirements
Module: cache_ctrl

---
 rtl/cache_pkg.sv | 45 ++++
 rtl/tag_store.sv | 50 +++++
 rtl/cache_ctrl.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Shared types and address-field layout for the direct-mapped cache controller.
package cache_pkg;

    localparam int ADDR_W      = 32;
    localparam int TAG_W       = 21;
    localparam int INDEX_W     = 6;
    localparam int WORD_W      = 3;
    localparam int LINES       = 64;
    localparam int OFFSET_W    = 5;
    localparam int DATA_ADDR_W = INDEX_W + WORD_W;

    localparam int TAG_LSB   = 11;
    localparam int INDEX_LSB = 5;
    localparam int WORD_LSB  = 2;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_COMPARE   = 2'd1,
        S_WRITEBACK = 2'd2,
        S_ALLOCATE  = 2'd3
    } state_e;

    typedef logic [TAG_W-1:0]   tag_t;
    typedef logic [INDEX_W-1:0] index_t;
    typedef logic [WORD_W-1:0]  word_t;

    typedef struct packed {
        logic valid;
        logic dirty;
        tag_t tag;
    } line_meta_t;

    function automatic tag_t addr_tag(input logic [ADDR_W-1:0] addr);
        return addr[TAG_LSB +: TAG_W];
    endfunction

    function automatic index_t addr_index(input logic [ADDR_W-1:0] addr);
        return addr[INDEX_LSB +: INDEX_W];
    endfunction

    function automatic word_t addr_word(input logic [ADDR_W-1:0] addr);
        return addr[WORD_LSB +: WORD_W];
    endfunction

endpackage

// File: rtl/tag_store.sv
// Per-line valid/dirty/tag storage: one combinational read port, one write port.
// Valid and dirty clear on reset; tags are left uninitialised.
module tag_store
    import cache_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  index_t     rd_index,
    output line_meta_t rd_meta,
    input  logic       wr_en,
    input  index_t     wr_index,
    input  line_meta_t wr_meta
);

    logic [LINES-1:0] valid_q, valid_d;
    logic [LINES-1:0] dirty_q, dirty_d;
    tag_t             tag_mem [LINES];

    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        if (wr_en) begin
            valid_d[wr_index] = wr_meta.valid;
            dirty_d[wr_index] = wr_meta.dirty;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[wr_index] <= wr_meta.tag;
        end
    end

    always_comb begin
        rd_meta.valid = valid_q[rd_index];
        rd_meta.dirty = dirty_q[rd_index];
        rd_meta.tag   = tag_mem[rd_index];
    end

endmodule

// File: rtl/cache_ctrl.sv
// Direct-mapped, write-back, write-allocate cache controller (64 lines x 8 words).
//   state     | meaning
//   IDLE      | not stalled; accepts cpu_req and latches address/we
//   COMPARE   | tag check; hit completes, miss starts writeback or allocate
//   WRITEBACK | waiting for wb_done on the dirty victim
//   ALLOCATE  | waiting for alloc_done, then refill metadata and re-compare
module cache_ctrl
    import cache_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cpu_req,
    input  logic                   cpu_we,
    input  logic [ADDR_W-1:0]      CPU_addr,
    output logic                   stall,
    output logic                   ready,
    output logic [ADDR_W-1:0]      line_addr,
    output logic                   alloc_start,
    input  logic                   alloc_done,
    output logic                   wb_start,
    output logic [ADDR_W-1:0]      wb_addr,
    input  logic                   wb_done,
    output logic                   data_we,
    output logic [DATA_ADDR_W-1:0] data_addr,
    output logic [15:0]            miss_count
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;
    logic [15:0]       miss_count_q, miss_count_d;

    index_t            req_index;
    tag_t              req_tag;
    line_meta_t        rd_meta;
    logic              ts_wr_en;
    line_meta_t        ts_wr_meta;
    logic              hit;
    logic [ADDR_W-1:0] victim_addr;

    assign req_index   = addr_index(addr_q);
    assign req_tag     = addr_tag(addr_q);
    assign hit         = rd_meta.valid && (rd_meta.tag == req_tag);
    assign victim_addr = {rd_meta.tag, req_index, {OFFSET_W{1'b0}}};

    tag_store u_tag_store (
        .clk      (clk),
        .rst      (rst),
        .rd_index (req_index),
        .rd_meta  (rd_meta),
        .wr_en    (ts_wr_en),
        .wr_index (req_index),
        .wr_meta  (ts_wr_meta)
    );

    always_comb begin
        state_d          = state_q;
        addr_d           = addr_q;
        we_d             = we_q;
        wb_addr_d        = wb_addr_q;
        miss_count_d     = miss_count_q;
        stall            = 1'b1;
        ready            = 1'b0;
        alloc_start      = 1'b0;
        wb_start         = 1'b0;
        data_we          = 1'b0;
        ts_wr_en         = 1'b0;
        ts_wr_meta.valid = 1'b1;
        ts_wr_meta.dirty = 1'b0;
        ts_wr_meta.tag   = req_tag;

        case (state_q)
            S_IDLE: begin
                stall = 1'b0;
                if (cpu_req) begin
                    addr_d  = CPU_addr;
                    we_d    = cpu_we;
                    state_d = S_COMPARE;
                end
            end
            S_COMPARE: begin
                if (hit) begin
                    ready   = 1'b1;
                    state_d = S_IDLE;
                    if (we_q) begin
                        data_we          = 1'b1;
                        ts_wr_en         = 1'b1;
                        ts_wr_meta.dirty = 1'b1;
                    end
                end else begin
                    if (miss_count_q != 16'hFFFF) begin
                        miss_count_d = miss_count_q + 16'd1;
                    end
                    if (rd_meta.valid && rd_meta.dirty) begin
                        wb_start  = 1'b1;
                        wb_addr_d = victim_addr;
                        state_d   = S_WRITEBACK;
                    end else begin
                        alloc_start = 1'b1;
                        state_d     = S_ALLOCATE;
                    end
                end
            end
            S_WRITEBACK: begin
                if (wb_done) begin
                    alloc_start = 1'b1;
                    state_d     = S_ALLOCATE;
                end
            end
            S_ALLOCATE: begin
                // Refill leaves the line clean; a store sets dirty on the re-compare hit.
                if (alloc_done) begin
                    ts_wr_en = 1'b1;
                    state_d  = S_COMPARE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            we_q         <= 1'b0;
            wb_addr_q    <= '0;
            miss_count_q <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            we_q         <= we_d;
            wb_addr_q    <= wb_addr_d;
            miss_count_q <= miss_count_d;
        end
    end

    // The victim address is live in the wb_start cycle and held in wb_addr_q afterwards.
    assign wb_addr    = wb_start ? victim_addr : wb_addr_q;
    assign line_addr  = addr_q;
    assign data_addr  = {req_index, addr_word(addr_q)};
    assign miss_count = miss_count_q;

endmodule
